// File: rtl/lane_car_counter_pkg.sv
// Shared definitions for the lane car counter and its DayTime consumer:
// lane indices, count widths, the count-array type and the saturating step.
package lane_car_counter_pkg;

  localparam int NUM_LANES = 8;
  localparam int COUNT_W   = 8;

  localparam int LANE_N1 = 0;
  localparam int LANE_N2 = 1;
  localparam int LANE_E1 = 2;
  localparam int LANE_E2 = 3;
  localparam int LANE_S1 = 4;
  localparam int LANE_S2 = 5;
  localparam int LANE_W1 = 6;
  localparam int LANE_W2 = 7;

  typedef logic [NUM_LANES-1:0]              lane_mask_t;
  typedef logic [NUM_LANES-1:0][COUNT_W-1:0] car_counts_t;

  // Saturating up/down step; simultaneous up and down cancel out.
  function automatic logic [COUNT_W-1:0] sat_step(
    input logic [COUNT_W-1:0] cur,
    input logic [COUNT_W-1:0] max_c,
    input logic               up,
    input logic               down
  );
    logic [COUNT_W-1:0] nxt;
    nxt = cur;
    case ({up, down})
      2'b10: begin
        if (cur < max_c) begin
          nxt = cur + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
          nxt = cur;
        end
      end
      2'b01: begin
        if (cur != {COUNT_W{1'b0}}) begin
          nxt = cur - {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
          nxt = cur;
        end
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lane_car_counter_lane.sv
// One lane: saturating up/down car counter with a sticky overflow flag
// that records arrivals lost while the count sat at MAX_COUNT.
module lane_counter
  import lane_car_counter_pkg::*;
#(
  parameter int MAX_COUNT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               ovf_o
);

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               ovf_q;
  logic               ovf_d;

  // Next count and overflow; only a lone arrival at the ceiling is lost.
  always_comb begin
    count_d = sat_step(count_q, MAX_C, inc_i, dec_i);
    ovf_d   = ovf_q;
    if (inc_i && !dec_i && (count_q >= MAX_C)) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= {COUNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/lane_car_counter.sv
// Eight-lane car counter. Define ARRIVAL_EDGE_DETECT_EN to treat arrive/depart
// as level sensors (count rising edges); otherwise each high cycle is one event.
module lane_car_counter
  import lane_car_counter_pkg::*;
#(
  parameter int MAX_COUNT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] arrive,
  input  logic [NUM_LANES-1:0] depart,
  input  logic [NUM_LANES-1:0] laneGreen,
  output car_counts_t          carCounts,
  output logic [NUM_LANES-1:0] ovf,
  output logic                 countValid
);

  lane_mask_t arr_evt;
  lane_mask_t dep_raw;
  lane_mask_t dep_evt;
  logic       valid_q;

`ifdef ARRIVAL_EDGE_DETECT_EN
  lane_mask_t arrive_q;
  lane_mask_t depart_q;

  // Sensor history; a red-light departure edge is consumed here, never replayed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arrive_q <= {NUM_LANES{1'b0}};
      depart_q <= {NUM_LANES{1'b0}};
    end else begin
      arrive_q <= arrive;
      depart_q <= depart;
    end
  end

  assign arr_evt = arrive & ~arrive_q;
  assign dep_raw = depart & ~depart_q;
`else
  assign arr_evt = arrive;
  assign dep_raw = depart;
`endif

  assign dep_evt = dep_raw & laneGreen;

  // countValid rises on the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
    end
  end

  assign countValid = valid_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_counter #(
      .MAX_COUNT(MAX_COUNT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (arr_evt[i]),
      .dec_i  (dep_evt[i]),
      .count_o(carCounts[i]),
      .ovf_o  (ovf[i])
    );
  end

endmodule

// File: doc/lane_car_counter.md
LANE_CAR_COUNTER -- requirements
Module: lane_car_counter

Interface
REQ-001 The block SHALL have parameter MAX_COUNT, default 255, the saturation ceiling per lane counter (1..255).
REQ-002 The block SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  in  1  synchronous, active-low reset.
REQ-004 The block SHALL have port arrive  in  8  per-lane arrival sensor; bit i = lane i (0 N1, 1 N2, 2 E1, 3 E2, 4 S1, 5 S2, 6 W1, 7 W2).
REQ-005 The block SHALL have port depart  in  8  per-lane departure sensor, same lane order.
REQ-006 The block SHALL have port laneGreen  in  8  current light state from DayTime laneOutput; bit i = 1 means lane i green.
REQ-007 The block SHALL have port carCounts  out  8x8 packed  per-lane car count, element i = lane i, unsigned; feeds DayTime carCounts.
REQ-008 The block SHALL have port ovf  out  8  sticky per-lane flag: an arrival was lost to saturation.
REQ-009 The block SHALL have port countValid  out  1  high once carCounts reflects at least one post-reset update cycle.

Function
REQ-010 Each lane SHALL count independently; an arrival event SHALL increment, a qualified departure event SHALL decrement.
REQ-011 A departure event on lane i SHALL be qualified only when laneGreen[i]=1 in the same cycle; unqualified departures SHALL be ignored.
REQ-012 Events sampled at rising edge n SHALL be visible on carCounts after edge n (one-cycle latency, registered output, no combinational input-to-output path).
REQ-013 Simultaneous arrival and qualified departure on a lane SHALL leave its count unchanged, including at 0 and at MAX_COUNT.
REQ-014 Arrival alone at count = MAX_COUNT SHALL hold the count and set ovf[i]; ovf[i] SHALL stay set until reset.
REQ-015 Qualified departure alone at count 0 SHALL hold 0 (no wrap) and SHALL NOT set ovf.
REQ-016 Counts SHALL never wrap in either direction.
REQ-017 countValid SHALL rise on the first rising edge after rst deasserts and stay high until the next reset.

Reset
REQ-018 While rst=0 at a rising edge: all carCounts = 0, ovf = 8'h00, countValid = 0, edge-detect history registers = 0.
REQ-019 Reset asserted mid-operation SHALL discard events sampled on that edge; no partial update.

Configuration
REQ-020 With ARRIVAL_EDGE_DETECT_EN defined: arrive and depart SHALL be level sensors; an event SHALL be a 0->1 transition against the previous-cycle registered value, one event per rising transition regardless of high duration.
REQ-021 Without ARRIVAL_EDGE_DETECT_EN: arrive and depart SHALL be single-cycle pulses; every cycle with the bit high SHALL be one event; no history registers.
REQ-022 With ARRIVAL_EDGE_DETECT_EN, a depart transition while laneGreen[i]=0 SHALL be consumed (history updated) and not counted later.

Structure
REQ-023 Shared package SHALL hold NUM_LANES=8, COUNT_W=8, lane index constants N1..W2, and the count-array typedef shared with DayTime.
REQ-024 One sub-module lane_counter (one lane: saturating up/down counter plus ovf) SHALL be instantiated NUM_LANES times.

Verification
REQ-025 Reset then one arrive pulse on lane 2 -> carCounts[2]=1 next cycle, other lanes 0, countValid=1.
REQ-026 Lane 7 at 4, depart pulse with laneGreen[7]=0 -> stays 4; repeat with laneGreen[7]=1 -> 3.
REQ-027 Lane 0 at 255 (MAX_COUNT default), arrive -> stays 255, ovf[0]=1; then depart green -> 254, ovf[0] still 1.
REQ-028 Lane 5 at 0, simultaneous arrive and green depart -> stays 0; lane 5 at 0, depart alone -> stays 0, ovf[5]=0.
REQ-029 ARRIVAL_EDGE_DETECT_EN defined, arrive[4] held high 5 cycles -> carCounts[4] increments by exactly 1; undefined -> increments by 5.
REQ-030 Counts nonzero, rst=0 for one edge mid-stream with arrivals active -> all counts 0, ovf 0, countValid 0 after that edge.
